// File: rtl/sum_datapath.sv
// sum_datapath: Sum/I registers with a shared adder for the sum-of-1..LIMIT loop.
// It also provides a registered OutPort, sticky overflow and strobe-conflict flags.
module sum_datapath #(
  parameter int I_W   = 8,
  parameter int SUM_W = 8,
  parameter int LIMIT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SumSrcMuxSel,
  input  logic             ISrcMuxSel,
  input  logic             SumEn,
  input  logic             IEn,
  input  logic             AdderSrcMuxSel,
  input  logic             OutPortEn,
  output logic             ILe10,
  output logic [SUM_W-1:0] OutPort,
  output logic             out_valid,
  output logic             ovf,
  output logic             ctrl_err
);
  logic [SUM_W-1:0] Sum;
  logic [I_W-1:0]   I;
  logic [SUM_W:0]   iExt, aOp, bOp, sum;
  logic             init, conflict, sumLoad, iLoad, sumOvf, iOvf;
  assign iExt     = (SUM_W+1)'(I);
  assign aOp      = AdderSrcMuxSel ? iExt : {1'b0, Sum};
  assign bOp      = AdderSrcMuxSel ? (SUM_W+1)'(1) : iExt;
  assign sum      = aOp + bOp;
  assign init     = SumEn & IEn & ~SumSrcMuxSel & ~ISrcMuxSel;
  assign conflict = SumEn & IEn & (SumSrcMuxSel | ISrcMuxSel);
  assign sumLoad  = SumEn & ~conflict;
  assign iLoad    = IEn & ~conflict;
  // overflow means the adder result lost bits when written to its destination
  assign sumOvf   = sumLoad & SumSrcMuxSel & sum[SUM_W];
  assign iOvf     = iLoad & ISrcMuxSel & (|sum[SUM_W:I_W]);
  assign ILe10    = I <= I_W'(LIMIT);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Sum       <= '0;
      I         <= '0;
      OutPort   <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      ctrl_err  <= 1'b0;
    end else begin
      if (sumLoad) Sum <= SumSrcMuxSel ? sum[SUM_W-1:0] : '0;
      if (iLoad) I <= ISrcMuxSel ? sum[I_W-1:0] : '0;
      if (OutPortEn) OutPort <= Sum;
      out_valid <= OutPortEn;
      ovf       <= init ? 1'b0 : (ovf | sumOvf | iOvf);
      ctrl_err  <= init ? 1'b0 : (ctrl_err | conflict);
    end
  end
endmodule

// File: tb/tb_sum_datapath.sv
// tb_sum_datapath: default and narrow (4-bit) datapaths driven by shared strobes.
// Both are compared against an integer-arithmetic model of the loop rules.
module tb_sum_datapath;
  logic clk = 1'b0, reset = 1'b1;
  logic SumSrcMuxSel = 0, ISrcMuxSel = 0, SumEn = 0, IEn = 0, AdderSrcMuxSel = 0, OutPortEn = 0;
  logic ILe0, ILe1, v0, v1, ovf0, ovf1, err0, err1;
  logic [7:0] out0;
  logic [3:0] out1;
  int total = 0, bad = 0;
  int mSum[2], mI[2], mOut[2], mV[2], mOvf[2], mErr[2];
  int seq0[11] = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 45, 55};
  int seq1[11] = '{0, 1, 3, 6, 10, 15, 5, 12, 4, 13, 7};

  always #5 clk = ~clk;

  sum_datapath dut0 (.clk(clk), .reset(reset), .SumSrcMuxSel(SumSrcMuxSel), .ISrcMuxSel(ISrcMuxSel),
    .SumEn(SumEn), .IEn(IEn), .AdderSrcMuxSel(AdderSrcMuxSel), .OutPortEn(OutPortEn),
    .ILe10(ILe0), .OutPort(out0), .out_valid(v0), .ovf(ovf0), .ctrl_err(err0));

  sum_datapath #(.I_W(4), .SUM_W(4), .LIMIT(10)) dut1 (.clk(clk), .reset(reset),
    .SumSrcMuxSel(SumSrcMuxSel), .ISrcMuxSel(ISrcMuxSel), .SumEn(SumEn), .IEn(IEn),
    .AdderSrcMuxSel(AdderSrcMuxSel), .OutPortEn(OutPortEn),
    .ILe10(ILe1), .OutPort(out1), .out_valid(v1), .ovf(ovf1), .ctrl_err(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset;
    for (int k = 0; k < 2; k++) begin
      mSum[k] = 0; mI[k] = 0; mOut[k] = 0; mV[k] = 0; mOvf[k] = 0; mErr[k] = 0;
    end
  endtask

  task automatic modelEdge;
    for (int k = 0; k < 2; k++) begin
      int m, s, nSum, nI;
      bit init, conf;
      m = (k == 0) ? 256 : 16;
      s = AdderSrcMuxSel ? mI[k] + 1 : mSum[k] + mI[k];
      init = SumEn && IEn && !SumSrcMuxSel && !ISrcMuxSel;
      conf = SumEn && IEn && (SumSrcMuxSel || ISrcMuxSel);
      mV[k] = OutPortEn;
      if (OutPortEn) mOut[k] = mSum[k];
      nSum = mSum[k];
      nI = mI[k];
      if (conf) mErr[k] = 1;
      else begin
        if (SumEn) begin
          if (SumSrcMuxSel && s >= m) mOvf[k] = 1;
          nSum = SumSrcMuxSel ? s % m : 0;
        end
        if (IEn) begin
          if (ISrcMuxSel && s >= m) mOvf[k] = 1;
          nI = ISrcMuxSel ? s % m : 0;
        end
        if (init) begin mOvf[k] = 0; mErr[k] = 0; end
      end
      mSum[k] = nSum;
      mI[k] = nI;
    end
  endtask

  task automatic checkAll;
    chk("out0", out0, mOut[0]);  chk("out1", out1, mOut[1]);
    chk("valid0", v0, mV[0]);    chk("valid1", v1, mV[1]);
    chk("ovf0", ovf0, mOvf[0]);  chk("ovf1", ovf1, mOvf[1]);
    chk("err0", err0, mErr[0]);  chk("err1", err1, mErr[1]);
    chk("ile0", ILe0, mI[0] <= 10); chk("ile1", ILe1, mI[1] <= 10);
  endtask

  task automatic step(input logic se, ie, ss, is, as, oe);
    SumEn = se; IEn = ie; SumSrcMuxSel = ss; ISrcMuxSel = is; AdderSrcMuxSel = as; OutPortEn = oe;
    @(posedge clk);
    modelEdge;
    @(negedge clk);
    checkAll;
  endtask

  task automatic initS;  step(1, 1, 0, 0, 0, 0); endtask
  task automatic addS;   step(1, 0, 1, 0, 0, 0); endtask
  task automatic incS(input logic oe); step(0, 1, 0, 1, 1, oe); endtask

  task automatic doReset;
    reset = 1'b1;
    modelReset;
    #1;
    checkAll;
    chk("rst.out0", out0, 0); chk("rst.ile0", ILe0, 1); chk("rst.ovf0", ovf0, 0); chk("rst.err0", err0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkAll;
  endtask

  task automatic fullLoop(input bit chkSeq);
    int n = 0;
    initS;
    while (mI[0] <= 10 && n < 20) begin
      addS;
      incS(1);
      if (chkSeq && n < 11) begin
        chk("seq0", out0, seq0[n]);
        chk("seq1", out1, seq1[n]);
      end
      n++;
    end
    chk("pulses", n, 11);
  endtask

  initial begin
    modelReset;
    #1;
    checkAll;
    @(negedge clk);
    reset = 1'b0;
    // full sum-of-1..10 loop on both widths
    fullLoop(1);
    chk("final.out0", out0, 55); chk("final.ile0", ILe0, 0); chk("final.ovf0", ovf0, 0);
    chk("final.ovf1", ovf1, 1);
    // conflicting strobes with Sum=3, I=2
    initS; incS(0); addS; incS(0); addS;
    step(1, 1, 1, 0, 0, 1);
    chk("conf.out0", out0, 3); chk("conf.err0", err0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("conf.hold", out0, 3); chk("conf.ile0", ILe0, 1);
    initS;
    chk("conf.clr", err0, 0);
    // OutPortEn on the same edge as a Sum load, Sum=6, I=4
    for (int j = 0; j < 4; j++) begin addS; incS(0); end
    step(1, 0, 1, 0, 0, 1);
    chk("same.out0", out0, 6); chk("same.v0", v0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("same.v0off", v0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("same.sum", out0, 10);
    step(0, 0, 0, 0, 0, 1);
    chk("b2b.v0", v0, 1);
    // reset mid-loop at Sum=28, I=8, then rerun
    initS;
    for (int j = 0; j < 8; j++) begin addS; incS(1); end
    chk("mid.out0", out0, 28);
    doReset;
    fullLoop(0);
    chk("rerun.out0", out0, 55);
    // random strobes with occasional resets
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 49) == 0) doReset;
      else step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
